// File: rtl/ether_receive.sv
// RMII receive MAC: strips preamble/SFD, assembles bytes LSB-first, checks the FCS
// and reports per-frame length and status alongside a one-byte-per-4-cycles stream.
module ether_receive #(
  parameter int MAX_BYTES = 1518,
  parameter int MIN_BYTES = 64,
  parameter int LEN_BITS  = 11
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                eth_crsdv,
  input  logic [1:0]          eth_rxd,
  output logic [7:0]          data_out,
  output logic                data_valid_out,
  output logic                frame_start_out,
  output logic                frame_done_out,
  output logic                frame_ok_out,
  output logic [LEN_BITS-1:0] frame_len_out
);

  localparam logic [LEN_BITS-1:0] MAX_LEN     = LEN_BITS'(MAX_BYTES);
  localparam logic [LEN_BITS-1:0] MIN_LEN     = LEN_BITS'(MIN_BYTES);
  localparam logic [LEN_BITS-1:0] OVER_LEN    = LEN_BITS'(MAX_BYTES + 1);
  localparam logic [31:0]         CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]         CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t              state, state_nxt;
  logic                dv;
  logic [1:0]          d;
  logic [1:0]          idx, idx_nxt;
  logic [5:0]          shreg, shreg_nxt;
  logic [LEN_BITS-1:0] count, count_nxt;
  logic [31:0]         crc, crc_nxt;
  logic [7:0]          byte_full;
  logic [7:0]          data_nxt;
  logic                valid_nxt, start_nxt, done_nxt, ok_nxt;
  logic [LEN_BITS-1:0] len_nxt;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // shreg holds the three earlier dibits; the current one completes the byte
  assign byte_full = {d, shreg};

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    count_nxt = count;
    crc_nxt   = crc;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    ok_nxt    = frame_ok_out;
    len_nxt   = frame_len_out;

    case (state)
      IDLE: begin
        if (dv && d == 2'b01) state_nxt = PREAMBLE;
      end

      PREAMBLE: begin
        if (!dv) begin
          state_nxt = IDLE;
        end else if (d == 2'b11) begin
          state_nxt = DATA;
          idx_nxt   = '0;
          count_nxt = '0;
          crc_nxt   = '1;
        end else if (d != 2'b01) begin
          state_nxt = IDLE;
        end
      end

      DATA: begin
        if (!dv) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          len_nxt   = count;
          ok_nxt    = (crc == CRC_RESIDUE) && (count >= MIN_LEN) &&
                      (count <= MAX_LEN) && (idx == 2'd0);
        end else begin
          shreg_nxt = byte_full[7:2];
          idx_nxt   = idx + 2'd1;
          if (idx == 2'd3) begin
            crc_nxt = crc_byte(crc, byte_full);
            // the byte that would exceed the limit is counted but never emitted
            if (count >= MAX_LEN) begin
              count_nxt = OVER_LEN;
              state_nxt = DROP;
            end else begin
              count_nxt = count + LEN_BITS'(1);
              data_nxt  = byte_full;
              valid_nxt = 1'b1;
              start_nxt = (count == '0);
            end
          end
        end
      end

      DROP: begin
        if (!dv) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          ok_nxt    = 1'b0;
          len_nxt   = OVER_LEN;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      dv              <= 1'b0;
      d               <= '0;
      idx             <= '0;
      shreg           <= '0;
      count           <= '0;
      crc             <= '1;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_ok_out    <= 1'b0;
      frame_len_out   <= '0;
    end else begin
      state           <= state_nxt;
      dv              <= eth_crsdv;
      d               <= eth_rxd;
      idx             <= idx_nxt;
      shreg           <= shreg_nxt;
      count           <= count_nxt;
      crc             <= crc_nxt;
      data_out        <= data_nxt;
      data_valid_out  <= valid_nxt;
      frame_start_out <= start_nxt;
      frame_done_out  <= done_nxt;
      frame_ok_out    <= ok_nxt;
      frame_len_out   <= len_nxt;
    end
  end

endmodule

// File: tb/tb_ether_receive.sv
// Bench for ether_receive: directed and random frames scored against a table-driven
// CRC-32 model and frame-level expectations.
module tb_ether_receive;
  localparam int MAXB = 1518;
  localparam int MINB = 64;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        eth_crsdv = 1'b0;
  logic [1:0]  eth_rxd = 2'b00;
  logic [7:0]  data_out;
  logic        data_valid_out, frame_start_out, frame_done_out, frame_ok_out;
  logic [10:0] frame_len_out;

  ether_receive #(.MAX_BYTES(MAXB), .MIN_BYTES(MINB), .LEN_BITS(11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .eth_crsdv(eth_crsdv), .eth_rxd(eth_rxd),
    .data_out(data_out), .data_valid_out(data_valid_out),
    .frame_start_out(frame_start_out), .frame_done_out(frame_done_out),
    .frame_ok_out(frame_ok_out), .frame_len_out(frame_len_out)
  );

  always #10 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  logic [31:0] crc_tab [256];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  start_q[$];
  logic [7:0]  exp_bytes_q[$];
  int done_ok_q[$], done_len_q[$], done_nv_q[$];
  int exp_ok_q[$], exp_len_q[$], exp_nv_q[$];
  int n_valid_frame = 0;
  int cyc = 0, last_valid_cyc = 0, last_gap = 0;

  // Output monitor: records strobes and per-frame results
  always @(negedge clk_in) begin
    cyc++;
    if (data_valid_out) begin
      rx_q.push_back(data_out);
      n_valid_frame++;
      last_valid_cyc = cyc;
    end
    if (frame_start_out) start_q.push_back(data_valid_out ? data_out : 8'hxx);
    if (frame_done_out) begin
      done_ok_q.push_back(int'(frame_ok_out));
      done_len_q.push_back(int'(frame_len_out));
      done_nv_q.push_back(n_valid_frame);
      n_valid_frame = 0;
      last_gap = cyc - last_valid_cyc;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_tab[(c[7:0] ^ tx_q[i])] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic bit fcs_ok(input int n);
    if (n < 4) return 1'b0;
    return crc32(n - 4) == {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
  endfunction

  task automatic build_frame(input int plen, input bit random_payload);
    logic [31:0] fcs;
    tx_q = {};
    for (int i = 0; i < plen; i++)
      tx_q.push_back(random_payload ? 8'($urandom) : 8'(i + 1));
    fcs = crc32(plen);
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(fcs >> (8 * i)));
  endtask

  task automatic drive_dibit(input logic [1:0] v);
    @(negedge clk_in);
    eth_crsdv = 1'b1;
    eth_rxd   = v;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      eth_crsdv = 1'b0;
      eth_rxd   = 2'b00;
    end
  endtask

  // Sends preamble, SFD and the first n_dibits of tx_q; optionally records expectations
  task automatic drive_frame(input int n_dibits, input int gap, input bit record);
    int full;
    if (record) begin
      full = n_dibits / 4;
      if (full > MAXB) begin
        exp_nv_q.push_back(MAXB);
        exp_len_q.push_back(MAXB + 1);
        exp_ok_q.push_back(0);
      end else begin
        exp_nv_q.push_back(full);
        exp_len_q.push_back(full);
        exp_ok_q.push_back(int'((n_dibits % 4 == 0) && full >= MINB && fcs_ok(full)));
      end
      for (int i = 0; i < ((full > MAXB) ? MAXB : full); i++) exp_bytes_q.push_back(tx_q[i]);
    end
    repeat (31) drive_dibit(2'b01);
    drive_dibit(2'b11);
    for (int k = 0; k < n_dibits; k++) begin
      logic [7:0] b;
      b = tx_q[k / 4];
      drive_dibit(2'(b >> (2 * (k % 4))));
    end
    drive_idle(gap);
  endtask

  task automatic check_frames(input string tag);
    int e_nv, e_ok, e_len, mism;
    logic [7:0] b;
    while (exp_nv_q.size() > 0) begin
      e_nv = exp_nv_q.pop_front();
      e_ok = exp_ok_q.pop_front();
      e_len = exp_len_q.pop_front();
      if (done_ok_q.size() == 0) begin
        check({tag, "/done_missing"}, 0, 1);
        exp_bytes_q = {};
        return;
      end
      check({tag, "/ok"}, done_ok_q.pop_front(), e_ok);
      check({tag, "/len"}, done_len_q.pop_front(), e_len);
      check({tag, "/strobes"}, done_nv_q.pop_front(), e_nv);
      if (e_nv > 0) begin
        check({tag, "/start_seen"}, start_q.size() > 0, 1);
        if (start_q.size() > 0) check({tag, "/start_byte"}, start_q.pop_front(), exp_bytes_q[0]);
      end
      mism = 0;
      for (int i = 0; i < e_nv; i++) begin
        b = exp_bytes_q.pop_front();
        if (rx_q.size() == 0) mism++;
        else if (rx_q.pop_front() !== b) mism++;
      end
      check({tag, "/bytes"}, mism, 0);
    end
    check({tag, "/extra_done"}, done_ok_q.size(), 0);
    check({tag, "/extra_bytes"}, rx_q.size(), 0);
    check({tag, "/extra_start"}, start_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end

    repeat (3) @(negedge clk_in);
    check("reset/data", data_out, 0);
    check("reset/strobes", {data_valid_out, frame_start_out, frame_done_out}, 0);
    check("reset/ok", frame_ok_out, 0);
    check("reset/len", frame_len_out, 0);
    rst_in = 1'b1;
    drive_idle(4);

    // Good 64-byte frame
    build_frame(60, 1'b0);
    drive_frame(64 * 4, 6, 1'b1);
    check_frames("good");
    check("good/last_valid_to_done", last_gap, 1);
    check("good/ok_held", frame_ok_out, 1);
    check("good/len_held", frame_len_out, 64);

    // Corrupted frame, then the original with a single idle cycle
    build_frame(60, 1'b0);
    tx_q[9] = tx_q[9] ^ 8'h01;
    drive_frame(64 * 4, 1, 1'b1);
    build_frame(60, 1'b0);
    drive_frame(64 * 4, 6, 1'b1);
    check_frames("corrupt_b2b");

    // Runt
    build_frame(20, 1'b0);
    drive_frame(24 * 4, 6, 1'b1);
    check_frames("runt");

    // Alignment error: carrier drops after 2 dibits of byte 30
    build_frame(60, 1'b0);
    drive_frame(29 * 4 + 2, 6, 1'b1);
    check_frames("align");

    // Oversize
    build_frame(1596, 1'b1);
    drive_frame(1600 * 4, 6, 1'b1);
    check_frames("oversize");

    // Bad preamble then a carrier that ends while still in preamble
    repeat (24) drive_dibit(2'b01);
    drive_dibit(2'b00);
    repeat (3) drive_dibit(2'b01);
    drive_idle(6);
    check_frames("bad_preamble");

    // Random frames, random corruption, short gaps
    for (int f = 0; f < 4; f++) begin
      build_frame($urandom_range(40, 120), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        int pos;
        pos = $urandom_range(0, tx_q.size() - 1);
        tx_q[pos] = tx_q[pos] ^ (8'h01 << $urandom_range(0, 7));
      end
      drive_frame(tx_q.size() * 4, (f == 3) ? 6 : $urandom_range(1, 4), 1'b1);
    end
    check_frames("random");

    // Good frame so the status is nonzero ahead of the reset
    build_frame(60, 1'b0);
    drive_frame(64 * 4, 6, 1'b1);
    check_frames("pre_reset");

    // Reset mid-frame at byte 12
    build_frame(60, 1'b0);
    drive_frame(12 * 4, 0, 1'b0);
    #5 rst_in = 1'b0;
    #1;
    check("midreset/data", data_out, 0);
    check("midreset/strobes", {data_valid_out, frame_start_out, frame_done_out}, 0);
    check("midreset/ok", frame_ok_out, 0);
    check("midreset/len", frame_len_out, 0);
    eth_crsdv = 1'b0;
    eth_rxd = 2'b00;
    rx_q = {};
    start_q = {};
    n_valid_frame = 0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    drive_idle(4);
    check_frames("midreset_nodone");

    build_frame(60, 1'b0);
    drive_frame(64 * 4, 6, 1'b1);
    check_frames("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
